// File: rtl/pri_encoder_83.sv
// Registered 8-to-3 priority encoder with request capture, enable gating,
// acknowledge handshake, pending count and a sticky overrun flag.
module pri_encoder_83 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iData,
    input  logic [1:0] iEna,
    input  logic       iAck,
    output logic [2:0] oData,
    output logic       oValid,
    output logic [3:0] oCount,
    output logic       oOverrun
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] prev;
    logic [7:0] pend;
    logic [7:0] pend_next;
    logic [7:0] rise;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic [2:0] top;
    logic [2:0] data_next;
    logic       overrun_next;

    // Capture is open only for G1 high and G2 low; edges while closed are dropped.
    always_comb begin
        rise     = iData & ~prev;
        set_mask = (iEna == 2'b10) ? rise : 8'h00;
    end

    // Ascending scan, so the highest set bit is the one left in top.
    always_comb begin
        top = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) begin
                top = i[2:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        data_next  = oData;
        clr_mask   = 8'h00;
        case (state)
            IDLE: begin
                if (pend != 8'h00) begin
                    data_next  = top;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (iAck) begin
                    clr_mask   = 8'h01 << oData;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Set wins over clear on the same bit; only an edge on a bit that stays pending overruns.
    always_comb begin
        pend_next    = (pend & ~clr_mask) | set_mask;
        overrun_next = oOverrun | (|(set_mask & pend & ~clr_mask));
    end

    always_comb begin
        oValid = (state == PRESENT);
        oCount = 4'd0;
        for (int i = 0; i < 8; i++) begin
            oCount = oCount + {3'b000, pend[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= 8'h00;
            pend     <= 8'h00;
            oData    <= 3'd0;
            oOverrun <= 1'b0;
        end else begin
            state    <= state_next;
            prev     <= iData;
            pend     <= pend_next;
            oData    <= data_next;
            oOverrun <= overrun_next;
        end
    end

endmodule

// File: tb/tb_pri_encoder_83.sv
// Bench for pri_encoder_83: a behavioural request/serve model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_pri_encoder_83;

    logic       clk;
    logic       rst;
    logic [7:0] iData;
    logic [1:0] iEna;
    logic       iAck;
    logic [2:0] oData;
    logic       oValid;
    logic [3:0] oCount;
    logic       oOverrun;

    int checks = 0;
    int errors = 0;

    pri_encoder_83 dut (
        .clk      (clk),
        .rst      (rst),
        .iData    (iData),
        .iEna     (iEna),
        .iAck     (iAck),
        .oData    (oData),
        .oValid   (oValid),
        .oCount   (oCount),
        .oOverrun (oOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: requests are a set of pending indices; one index is being shown or none.
    bit m_started = 0;
    bit m_prev[8];
    bit m_pend[8];
    bit m_showing;
    int m_code;
    bit m_ovr;

    function automatic int model_count();
        int c = 0;
        for (int n = 0; n < 8; n++) c += m_pend[n] ? 1 : 0;
        return c;
    endfunction

    always @(posedge clk) begin
        bit new_pend[8];
        bit acked;
        bit open;
        int best;
        if (rst) begin
            m_started = 1;
            for (int n = 0; n < 8; n++) begin
                m_prev[n] = 0;
                m_pend[n] = 0;
            end
            m_showing = 0;
            m_code    = 0;
            m_ovr     = 0;
        end else if (m_started) begin
            acked = m_showing && (iAck == 1'b1);
            open  = (iEna[1] == 1'b1) && (iEna[0] == 1'b0);
            new_pend = m_pend;
            if (acked) new_pend[m_code] = 0;
            for (int n = 0; n < 8; n++) begin
                if (open && iData[n] && !m_prev[n]) begin
                    if (m_pend[n] && !(acked && n == m_code)) m_ovr = 1;
                    new_pend[n] = 1;
                end
            end
            if (m_showing) begin
                if (iAck) m_showing = 0;
            end else begin
                best = -1;
                for (int n = 7; n >= 0; n--) begin
                    if (best < 0 && m_pend[n]) best = n;
                end
                if (best >= 0) begin
                    m_code    = best;
                    m_showing = 1;
                end
            end
            m_pend = new_pend;
            for (int n = 0; n < 8; n++) m_prev[n] = iData[n];
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("model_oValid", int'(oValid), int'(m_showing));
            checkOutput("model_oData", int'(oData), m_code);
            checkOutput("model_oCount", int'(oCount), model_count());
            checkOutput("model_oOverrun", int'(oOverrun), int'(m_ovr));
        end
    end

    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic [1:0] e, input logic a);
        rst   = r;
        iData = d;
        iEna  = e;
        iAck  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input int v, input int d, input int c, input int o);
        checkOutput({tag, "_oValid"}, int'(oValid), v);
        if (d >= 0) checkOutput({tag, "_oData"}, int'(oData), d);
        checkOutput({tag, "_oCount"}, int'(oCount), c);
        if (o >= 0) checkOutput({tag, "_oOverrun"}, int'(oOverrun), o);
    endtask

    initial begin
        logic [1:0] bad_ena [3];
        bad_ena[0] = 2'b01;
        bad_ena[1] = 2'b11;
        bad_ena[2] = 2'b00;

        rst = 1'b1; iData = 8'h00; iEna = 2'b10; iAck = 1'b0;
        @(negedge clk);
        applyStimulus(1, 8'h00, 2'b10, 0);
        applyStimulus(1, 8'h00, 2'b10, 0);
        expectOut("reset", 0, 0, 0, 0);

        // Single request on bit 3
        applyStimulus(0, 8'h08, 2'b10, 0);
        expectOut("single_capture", 0, 0, 1, 0);
        applyStimulus(0, 8'h08, 2'b10, 0);
        expectOut("single_present", 1, 3, 1, 0);
        applyStimulus(0, 8'h08, 2'b10, 1);
        expectOut("single_ack", 0, 3, 0, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);
        expectOut("single_idle_hold", 0, 3, 0, 0);

        // Priority 7, 2, 0 with iAck held high
        applyStimulus(0, 8'h85, 2'b10, 0);
        expectOut("prio_capture", 0, -1, 3, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_code7", 1, 7, 3, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_gap1", 0, 7, 2, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_code2", 1, 2, 2, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_gap2", 0, 2, 1, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_code0", 1, 0, 1, 0);
        applyStimulus(0, 8'h85, 2'b10, 1);
        expectOut("prio_done", 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);

        // Enable gating
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 8'h10, bad_ena[k], 0);
            applyStimulus(0, 8'h00, bad_ena[k], 0);
            expectOut("gate_off", 0, 0, 0, 0);
            applyStimulus(0, 8'h00, 2'b10, 0);
            expectOut("gate_off_late", 0, 0, 0, 0);
        end
        applyStimulus(0, 8'h10, 2'b10, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);
        expectOut("gate_on", 1, 4, 1, 0);
        applyStimulus(0, 8'h00, 2'b10, 1);
        applyStimulus(0, 8'h00, 2'b10, 0);
        expectOut("gate_cleared", 0, 4, 0, 0);

        // Overrun, then set-wins on acknowledge
        applyStimulus(0, 8'h04, 2'b10, 0);
        applyStimulus(0, 8'h04, 2'b10, 0);
        expectOut("ovr_present", 1, 2, 1, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);
        applyStimulus(0, 8'h04, 2'b10, 0);
        expectOut("ovr_flag", 1, 2, 1, 1);
        applyStimulus(0, 8'h00, 2'b10, 0);
        applyStimulus(0, 8'h04, 2'b10, 1);
        expectOut("setwins_gap", 0, 2, 1, 1);
        applyStimulus(0, 8'h04, 2'b10, 0);
        expectOut("setwins_again", 1, 2, 1, 1);
        applyStimulus(0, 8'h04, 2'b10, 1);
        applyStimulus(0, 8'h00, 2'b10, 0);
        expectOut("setwins_done", 0, 2, 0, 1);

        // No preemption by a higher request
        applyStimulus(0, 8'h02, 2'b10, 0);
        applyStimulus(0, 8'h02, 2'b10, 0);
        expectOut("nopre_code1", 1, 1, 1, 1);
        applyStimulus(0, 8'h42, 2'b10, 0);
        expectOut("nopre_hold", 1, 1, 2, 1);
        applyStimulus(0, 8'h42, 2'b10, 0);
        expectOut("nopre_hold2", 1, 1, 2, 1);
        applyStimulus(0, 8'h42, 2'b10, 1);
        expectOut("nopre_gap", 0, 1, 1, 1);
        applyStimulus(0, 8'h42, 2'b10, 0);
        expectOut("nopre_code6", 1, 6, 1, 1);
        applyStimulus(0, 8'h42, 2'b10, 1);
        applyStimulus(0, 8'h00, 2'b10, 0);

        // Reset mid-operation with a request held high
        applyStimulus(0, 8'h0E, 2'b10, 0);
        applyStimulus(0, 8'h0E, 2'b10, 0);
        expectOut("rstmid_before", 1, 3, 3, 1);
        applyStimulus(1, 8'h01, 2'b10, 1);
        expectOut("rstmid_reset", 0, 0, 0, 0);
        applyStimulus(0, 8'h01, 2'b10, 0);
        expectOut("rstmid_capture", 0, 0, 1, 0);
        applyStimulus(0, 8'h01, 2'b10, 0);
        expectOut("rstmid_code0", 1, 0, 1, 0);
        applyStimulus(0, 8'h01, 2'b10, 1);
        expectOut("rstmid_done", 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);
        applyStimulus(0, 8'h00, 2'b10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pri_encoder_83.md
PRI_ENCODER_83 -- requirements
Module: pri_encoder_83

Interface
REQ-001 SHALL have no parameters; 8 request lines and a 3-bit code are fixed.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: iData  input  8  request lines; bit n = request for code n.
REQ-005 SHALL have port: iEna  input  2  enable pair; G1=iEna[1] active high, G2=iEna[0] active low; capture enabled only when iEna==2'b10.
REQ-006 SHALL have port: iAck  input  1  consumer acknowledge of the presented code.
REQ-007 SHALL have port: oData  output  3  encoded index of the served request.
REQ-008 SHALL have port: oValid  output  1  oData holds a valid code awaiting iAck.
REQ-009 SHALL have port: oCount  output  4  number of pending requests, 0..8.
REQ-010 SHALL have port: oOverrun  output  1  sticky flag: a request edge arrived on an already-pending bit.

Function
REQ-011 SHALL register iData into prev[7:0] every cycle regardless of iEna; edge[n] = iData[n] & ~prev[n].
REQ-012 SHALL set pend[n] at a clock edge when edge[n]=1 and iEna==2'b10; edges while disabled are discarded, not deferred.
REQ-013 SHALL keep serving already-pending bits while disabled (iEna affects capture only).
REQ-014 SHALL implement FSM states IDLE and PRESENT.
REQ-015 IDLE: oValid=0; if pend!=0, latch sel = index of highest set pend bit (bit 7 highest priority) into oData and go to PRESENT.
REQ-016 PRESENT: oValid=1, oData held stable; leave only on iAck=1.
REQ-017 On iAck=1 in PRESENT, SHALL clear pend[sel] and go to IDLE; one IDLE cycle (oValid=0) always separates consecutive codes.
REQ-018 SHALL ignore iAck in IDLE (no state change, no pend change).
REQ-019 Latency: iData[n] rises before edge k with iEna==2'b10 and pend=0 -> pend[n]=1 after edge k, oValid=1 with oData=n after edge k+1.
REQ-020 Simultaneous set and clear of the same bit (new edge on sel during acknowledged cycle) -> set wins; bit remains pending and is re-presented.
REQ-021 Edge on bit n with pend[n] already 1 (and not being cleared that cycle) -> pend unchanged, oOverrun set to 1; oOverrun cleared only by rst.
REQ-022 Higher-priority request arriving while PRESENT SHALL NOT preempt the current code; it is selected at the next IDLE.
REQ-023 oCount SHALL equal the population count of pend, registered-consistent with pend (same cycle).
REQ-024 oData SHALL retain its last value in IDLE when pend=0.

Reset
REQ-025 At a clock edge with rst=1: state=IDLE, pend=0, prev=8'h00, oData=3'd0, oValid=0, oCount=0, oOverrun=0.
REQ-026 Reset mid-operation (PRESENT or pending requests) SHALL discard all pending requests and any unacknowledged code; iAck during rst ignored.
REQ-027 A request line already high when rst deasserts SHALL register as a rising edge on the first post-reset cycle (prev cleared to 0).

Verification
REQ-028 Single request: iEna=2'b10, iData 8'h00->8'h08 -> after 2 edges oValid=1, oData=3, oCount=1; iAck one cycle -> oValid=0, oCount=0.
REQ-029 Priority: iData 8'h00->8'h85 in one cycle -> oCount=3; codes served in order 7, 2, 0, each separated by one oValid=0 cycle with iAck held high.
REQ-030 Enable gating: iEna=2'b01, 2'b11, 2'b00 with iData pulse 8'h10 -> pend stays 0, oValid never asserts; iEna=2'b10 with same pulse -> oData=4.
REQ-031 Overrun and set-wins: bit 2 pending, drop and re-raise iData[2] while not acknowledged -> oOverrun=1, oCount=1; re-raise in same cycle as iAck for code 2 -> code 2 presented again.
REQ-032 No preemption: code 1 presented, raise iData[6] -> oData stays 1 until iAck, next code 6.
REQ-033 Reset mid-operation: 3 pending, oValid=1, assert rst one cycle with iData=8'h01 held -> all outputs 0; next cycles code 0 presented (prev cleared).
